// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   Sequencer sitting directly in front of the 64x16 data RAM. It is the only
//   driver of the RAM strobes, addresses and write data. CPU control hands it
//   load, store and block-copy requests over a valid/ready handshake. Each
//   request ends with a one-cycle response pulse that carries an error flag.
//   Load data is also returned with the pulse. The register bank (A=63, B=62,
//   C=61, D=60) lives in the RAM like any other word.
//
//   Optional feature macro: COPY_EN
//     defined   : op 2'b10 performs a forward block copy, 2 cycles per word
//     undefined : the copy datapath is absent. Op 2'b10 answers with
//                 resp_err=1 one cycle after accept and makes no RAM access.
//
// Ports
//   clk            in   1       clock, all state changes on posedge
//   rst            in   1       asynchronous active-high reset
//   req_valid      in   1       request present
//   req_ready      out  1       high only while idle
//   req_op         in   2       00 load, 01 store, 10 copy, 11 illegal
//   req_addr       in   ADDR_W  load/store address, copy source base
//   req_dst        in   ADDR_W  copy destination base
//   req_len        in   ADDR_W  copy word count
//   req_wdata      in   DATA_W  store data
//   resp_valid     out  1       one-cycle completion pulse
//   resp_err       out  1       illegal/unsupported op, valid with resp_valid
//   resp_data      out  DATA_W  last load result, held until the next load
//   busy           out  1       inverse of req_ready
//   ram_read       out  1       RAM read enable
//   ram_write      out  1       RAM write enable
//   ram_read_addr  out  ADDR_W  RAM read address
//   ram_write_addr out  ADDR_W  RAM write address
//   ram_wdata      out  DATA_W  RAM write data
//   ram_rdata      in   DATA_W  RAM combinational read data
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_dst,
    input  logic [ADDR_W-1:0] req_len,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_data,
    output logic              busy,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_read_addr,
    output logic [ADDR_W-1:0] ram_write_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
`ifdef COPY_EN
    localparam logic [1:0] OP_COPY  = 2'b10;
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_STORE   = 3'd2,
`ifdef COPY_EN
        ST_COPY_RD = 3'd4,
        ST_COPY_WR = 3'd5,
`endif
        ST_RESP    = 3'd3
    } state_t;

    state_t              state_r;
    logic                req_ready_r;
    logic                busy_r;
    logic                resp_valid_r;
    logic                resp_err_r;
    logic [DATA_W-1:0]   resp_data_r;
    logic                ram_read_r;
    logic                ram_write_r;
    logic [ADDR_W-1:0]   ram_read_addr_r;
    logic [ADDR_W-1:0]   ram_write_addr_r;
    // During a copy this register also acts as the word buffer between the
    // read phase and the write phase.
    logic [DATA_W-1:0]   ram_wdata_r;

`ifdef COPY_EN
    logic [ADDR_W-1:0]   src_r;
    logic [ADDR_W-1:0]   dst_r;
    logic [ADDR_W-1:0]   len_r;
    logic [ADDR_W-1:0]   cnt_r;
    logic [ADDR_W-1:0]   cnt_next_s;

    // Word index after the current write. It never overflows because cnt_r < len_r <= 2**ADDR_W-1.
    assign cnt_next_s = cnt_r + ADDR_W'(1);
`else
    logic                unused_copy_s;

    // Copy-only request fields have no consumer in this build.
    assign unused_copy_s = ^{req_dst, req_len};
`endif

    assign req_ready      = req_ready_r;
    assign busy           = busy_r;
    assign resp_valid     = resp_valid_r;
    assign resp_err       = resp_err_r;
    assign resp_data      = resp_data_r;
    assign ram_read       = ram_read_r;
    assign ram_write      = ram_write_r;
    assign ram_read_addr  = ram_read_addr_r;
    assign ram_write_addr = ram_write_addr_r;
    assign ram_wdata      = ram_wdata_r;

    // Sequencer FSM. State, RAM strobes/addresses and response outputs are all registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r          <= ST_IDLE;
            req_ready_r      <= 1'b1;
            busy_r           <= 1'b0;
            resp_valid_r     <= 1'b0;
            resp_err_r       <= 1'b0;
            resp_data_r      <= {DATA_W{1'b0}};
            ram_read_r       <= 1'b0;
            ram_write_r      <= 1'b0;
            ram_read_addr_r  <= {ADDR_W{1'b0}};
            ram_write_addr_r <= {ADDR_W{1'b0}};
            ram_wdata_r      <= {DATA_W{1'b0}};
`ifdef COPY_EN
            src_r            <= {ADDR_W{1'b0}};
            dst_r            <= {ADDR_W{1'b0}};
            len_r            <= {ADDR_W{1'b0}};
            cnt_r            <= {ADDR_W{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        // Accept edge: latch the request and leave IDLE.
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        case (req_op)
                            OP_LOAD: begin
                                state_r         <= ST_LOAD;
                                ram_read_r      <= 1'b1;
                                ram_read_addr_r <= req_addr;
                            end
                            OP_STORE: begin
                                state_r          <= ST_STORE;
                                ram_write_r      <= 1'b1;
                                ram_write_addr_r <= req_addr;
                                ram_wdata_r      <= req_wdata;
                            end
`ifdef COPY_EN
                            OP_COPY: begin
                                src_r <= req_addr;
                                dst_r <= req_dst;
                                len_r <= req_len;
                                cnt_r <= {ADDR_W{1'b0}};
                                if (req_len == {ADDR_W{1'b0}}) begin
                                    // Empty copy: answer at once and leave the RAM untouched.
                                    state_r      <= ST_RESP;
                                    resp_valid_r <= 1'b1;
                                    resp_err_r   <= 1'b0;
                                end else begin
                                    state_r         <= ST_COPY_RD;
                                    ram_read_r      <= 1'b1;
                                    ram_read_addr_r <= req_addr;
                                end
                            end
`endif
                            default: begin
                                // Illegal op, or copy when it is not built in.
                                state_r      <= ST_RESP;
                                resp_valid_r <= 1'b1;
                                resp_err_r   <= 1'b1;
                            end
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_LOAD: begin
                    resp_data_r  <= ram_rdata;
                    ram_read_r   <= 1'b0;
                    state_r      <= ST_RESP;
                    resp_valid_r <= 1'b1;
                    resp_err_r   <= 1'b0;
                end

                ST_STORE: begin
                    ram_write_r  <= 1'b0;
                    state_r      <= ST_RESP;
                    resp_valid_r <= 1'b1;
                    resp_err_r   <= 1'b0;
                end

`ifdef COPY_EN
                ST_COPY_RD: begin
                    ram_read_r       <= 1'b0;
                    ram_wdata_r      <= ram_rdata;
                    ram_write_r      <= 1'b1;
                    ram_write_addr_r <= dst_r + cnt_r;
                    state_r          <= ST_COPY_WR;
                end

                ST_COPY_WR: begin
                    ram_write_r <= 1'b0;
                    cnt_r       <= cnt_next_s;
                    // The next read comes after this write commits. Overlapping copies
                    // therefore re-read words that were already copied (forward copy).
                    if (cnt_next_s < len_r) begin
                        state_r         <= ST_COPY_RD;
                        ram_read_r      <= 1'b1;
                        ram_read_addr_r <= src_r + cnt_next_s;
                    end else begin
                        state_r      <= ST_RESP;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b0;
                    end
                end
`endif

                ST_RESP: begin
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    req_ready_r  <= 1'b1;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end

                default: begin
                    // Unreachable encoding: recover to a quiet IDLE.
                    state_r      <= ST_IDLE;
                    req_ready_r  <= 1'b1;
                    busy_r       <= 1'b0;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    ram_read_r   <= 1'b0;
                    ram_write_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl. A behavioural RAM sits on the RAM port.
// A transaction-level model predicts every output on every cycle, and
// directed tests pin the model with hand-computed values.
module tb_mem_access_ctrl;

    localparam int AW = 6;
    localparam int DW = 16;
`ifdef COPY_EN
    localparam bit COPY_ON = 1'b1;
`else
    localparam bit COPY_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_init = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [AW-1:0] req_addr = 6'd0;
    logic [AW-1:0] req_dst = 6'd0;
    logic [AW-1:0] req_len = 6'd0;
    logic [DW-1:0] req_wdata = 16'h0000;
    logic          resp_valid;
    logic          resp_err;
    logic [DW-1:0] resp_data;
    logic          busy;
    logic          ram_read;
    logic          ram_write;
    logic [AW-1:0] ram_read_addr;
    logic [AW-1:0] ram_write_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic [DW-1:0] mem [64];
    int checks = 0;
    int failures = 0;

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_dst(req_dst), .req_len(req_len), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_data(resp_data), .busy(busy),
        .ram_read(ram_read), .ram_write(ram_write),
        .ram_read_addr(ram_read_addr), .ram_write_addr(ram_write_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Data RAM: initial contents 16'h1000+i, writes commit on posedge, reads are combinational.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 16'h1000 + 16'(i);
        end else if (ram_write) begin
            mem[ram_write_addr] <= ram_wdata;
        end
    end
    assign ram_rdata = mem[ram_read_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction model plus per-cycle compare, evaluated on every negedge.
    initial begin : model
        logic [DW-1:0] ref_mem [64];
        bit            m_active;
        int            m_rel, m_L, k;
        logic [1:0]    m_op;
        logic [AW-1:0] m_src, m_dst, m_len;
        logic [DW-1:0] m_wd, exp_rdata, e_wdata;
        bit            m_err, e_ready, e_resp, e_rd, e_wr;
        logic [AW-1:0] e_raddr, e_waddr;
        for (int i = 0; i < 64; i++) ref_mem[i] = 16'h1000 + 16'(i);
        m_active = 1'b0; m_rel = 0; m_L = 1; m_op = 2'b00; m_src = 6'd0; m_dst = 6'd0;
        m_len = 6'd0; m_wd = 16'h0000; m_err = 1'b0; exp_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_active  = 1'b0;
                exp_rdata = 16'h0000;
                chk("rst_req_ready", 32'(req_ready), 32'd1);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_resp_valid", 32'(resp_valid), 32'd0);
                chk("rst_resp_err", 32'(resp_err), 32'd0);
                chk("rst_resp_data", 32'(resp_data), 32'd0);
                chk("rst_ram_read", 32'(ram_read), 32'd0);
                chk("rst_ram_write", 32'(ram_write), 32'd0);
                chk("rst_raddr", 32'(ram_read_addr), 32'd0);
                chk("rst_waddr", 32'(ram_write_addr), 32'd0);
                chk("rst_wdata", 32'(ram_wdata), 32'd0);
            end else begin
                e_ready = !m_active || (m_rel >= m_L);
                e_resp  = m_active && (m_rel == m_L - 1);
                k       = m_rel / 2;
                e_rd = m_active && ((m_op == 2'b00 && m_rel == 0) ||
                       (m_op == 2'b10 && COPY_ON && m_rel < 2 * int'(m_len) && (m_rel % 2) == 0));
                e_wr = m_active && ((m_op == 2'b01 && m_rel == 0) ||
                       (m_op == 2'b10 && COPY_ON && m_rel < 2 * int'(m_len) && (m_rel % 2) == 1));
                e_raddr = (m_op == 2'b00) ? m_src : m_src + 6'(k);
                e_waddr = (m_op == 2'b01) ? m_src : m_dst + 6'(k);
                e_wdata = (m_op == 2'b01) ? m_wd : ref_mem[m_src + 6'(k)];
                chk("cyc_req_ready", 32'(req_ready), 32'(e_ready));
                chk("cyc_busy", 32'(busy), 32'(!e_ready));
                chk("cyc_resp_valid", 32'(resp_valid), 32'(e_resp));
                chk("cyc_ram_read", 32'(ram_read), 32'(e_rd));
                chk("cyc_ram_write", 32'(ram_write), 32'(e_wr));
                chk("cyc_resp_data", 32'(resp_data), 32'(exp_rdata));
                if (e_rd) chk("cyc_raddr", 32'(ram_read_addr), 32'(e_raddr));
                if (e_wr) begin
                    chk("cyc_waddr", 32'(ram_write_addr), 32'(e_waddr));
                    chk("cyc_wdata", 32'(ram_wdata), 32'(e_wdata));
                end
                if (e_resp) chk("cyc_resp_err", 32'(resp_err), 32'(m_err));
                // Advance the model to the next cycle.
                if (e_wr) ref_mem[e_waddr] = e_wdata;
                if (e_rd && m_op == 2'b00) exp_rdata = ref_mem[e_raddr];
                if (m_active) m_rel++;
                if (e_ready && req_valid) begin
                    m_active = 1'b1; m_rel = 0; m_op = req_op; m_src = req_addr;
                    m_dst = req_dst; m_len = req_len; m_wd = req_wdata;
                    m_err = (req_op == 2'b11) || (req_op == 2'b10 && !COPY_ON);
                    if (req_op == 2'b00 || req_op == 2'b01) m_L = 2;
                    else if (req_op == 2'b10 && COPY_ON) m_L = (req_len == 6'd0) ? 1 : 2 * int'(req_len) + 1;
                    else m_L = 1;
                end
            end
        end
    end

    // Issue one request and wait for its response. The latency is counted from the accept edge.
    task automatic do_req(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] d,
                          input logic [AW-1:0] l, input logic [DW-1:0] w,
                          output int lat, output logic [DW-1:0] rd, output logic re);
        int n;
        req_op = op; req_addr = a; req_dst = d; req_len = l; req_wdata = w;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
        chk("ready_wait_bound", 32'(n < 200), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (lat < 300) begin
            @(negedge clk);
            if (resp_valid) break;
            @(posedge clk);
            lat++;
        end
        chk("resp_wait_bound", 32'(lat < 300), 32'd1);
        rd = resp_data; re = resp_err;
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : stim
        int lat, n;
        logic [DW-1:0] rd;
        logic re;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; mem_init = 1'b0;
        @(posedge clk); #1;

        // 1: store 0xBEEF @63, then load it back.
        do_req(2'b01, 6'd63, 6'd0, 6'd0, 16'hBEEF, lat, rd, re);
        chk("t1_store_lat", 32'(lat), 32'd2);
        chk("t1_store_err", 32'(re), 32'd0);
        do_req(2'b00, 6'd63, 6'd0, 6'd0, 16'h0000, lat, rd, re);
        chk("t1_load_lat", 32'(lat), 32'd2);
        chk("t1_load_data", 32'(rd), 32'hBEEF);
        chk("t1_load_err", 32'(re), 32'd0);

        // 2: store 1..4 @60..63, then copy 60 -> 10 with len 4.
        for (int i = 0; i < 4; i++) do_req(2'b01, 6'(60 + i), 6'd0, 6'd0, 16'(i + 1), lat, rd, re);
        do_req(2'b10, 6'd60, 6'd10, 6'd4, 16'h0000, lat, rd, re);
`ifdef COPY_EN
        chk("t2_copy_lat", 32'(lat), 32'd9);
        chk("t2_copy_err", 32'(re), 32'd0);
        for (int i = 0; i < 4; i++) chk("t2_copy_word", 32'(mem[10 + i]), 32'(i + 1));
`else
        chk("t2_copy_lat", 32'(lat), 32'd1);
        chk("t2_copy_err", 32'(re), 32'd1);
        chk("t2_no_write", 32'(mem[10]), 32'h100A);
`endif

        // 3: a wrapping copy 62 -> 0 with len 3. Source word 0 is read after word 0 was
        // already written, so it returns the copied value 3.
        do_req(2'b10, 6'd62, 6'd0, 6'd3, 16'h0000, lat, rd, re);
`ifdef COPY_EN
        chk("t3_wrap_lat", 32'(lat), 32'd7);
        chk("t3_wrap_w0", 32'(mem[0]), 32'h0003);
        chk("t3_wrap_w1", 32'(mem[1]), 32'h0004);
        chk("t3_wrap_w2", 32'(mem[2]), 32'h0003);
`else
        chk("t3_wrap_err", 32'(re), 32'd1);
        chk("t3_no_write", 32'(mem[0]), 32'h1000);
`endif
        do_req(2'b10, 6'd5, 6'd7, 6'd0, 16'h0000, lat, rd, re);
        chk("t3_len0_lat", 32'(lat), 32'd1);
        chk("t3_len0_err", 32'(re), 32'(!COPY_ON));

        // 4: illegal op.
        do_req(2'b11, 6'd5, 6'd7, 6'd2, 16'h1234, lat, rd, re);
        chk("t4_illegal_lat", 32'(lat), 32'd1);
        chk("t4_illegal_err", 32'(re), 32'd1);

        // 5: hold req_valid through a load while the other fields keep changing.
        req_op = 2'b00; req_addr = 6'd60; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        lat = 1; rd = 16'h0000;
        for (int c = 0; c < 20; c++) begin
            req_op = 2'b01; req_addr = 6'(c); req_wdata = 16'hDEAD + 16'(c);
            @(negedge clk);
            if (resp_valid) begin rd = resp_data; req_valid = 1'b0; break; end
            @(posedge clk); #1;
            lat++;
        end
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_lat", 32'(lat), 32'd2);
        chk("t5_data", 32'(rd), 32'h0001);
        chk("t5_mem60_kept", 32'(mem[60]), 32'h0001);
        chk("t5_ready_back", 32'(req_ready), 32'd1);

        // 6: reset during the write phase of word 2 of a 5-word copy 20 -> 40.
        req_op = 2'b10; req_addr = 6'd20; req_dst = 6'd40; req_len = 6'd5; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
`ifdef COPY_EN
        chk("t6_write_before_rst", 32'(ram_write), 32'd1);
`endif
        rst = 1'b1;
        #1;
        chk("t6_write_dropped", 32'(ram_write), 32'd0);
        chk("t6_ready_on_rst", 32'(req_ready), 32'd1);
        chk("t6_no_resp", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
`ifdef COPY_EN
        chk("t6_w0_copied", 32'(mem[40]), 32'h1014);
        chk("t6_w1_copied", 32'(mem[41]), 32'h1015);
        chk("t6_w2_untouched", 32'(mem[42]), 32'h102A);
        do_req(2'b00, 6'd41, 6'd0, 6'd0, 16'h0000, lat, rd, re);
        chk("t6_load_after", 32'(rd), 32'h1015);
`else
        do_req(2'b00, 6'd41, 6'd0, 6'd0, 16'h0000, lat, rd, re);
        chk("t6_load_after", 32'(rd), 32'h1029);
`endif
        chk("t6_load_lat", 32'(lat), 32'd2);
        chk("t6_load_err", 32'(re), 32'd0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
